// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit-address processor: opcodes, instruction field positions,
// sequencer state encoding and instruction classes. Used by sequencer, datapath and ROM.
package proc_pkg;

    localparam int PC_W_DEF = 4;
    localparam int IW_DEF   = 16;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b1101;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_OUT,
        CL_JMP,
        CL_HALT
    } iclass_t;

    function automatic logic [3:0] get_opcode(input logic [15:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Sequencer <-> ROM/datapath bundle. master = sequencer, slave = datapath/ROM side.
interface proc_sequencer_if #(
    parameter int PC_W = 4,
    parameter int IW   = 16
);
    // No valid/ready pair here: run is a level request sampled only in IDLE and at
    // instruction end, ex_busy is a stall honoured only in EXECUTE, and the strobes
    // alu_en/reg_we/out_en are single-owner pulses with no back-pressure.
    logic            run;
    logic            ex_busy;
    logic [PC_W-1:0] rom_addr;
    logic [IW-1:0]   rom_data;
    logic [IW-1:0]   ir;
    logic            alu_en;
    logic            reg_we;
    logic            out_en;
    logic            halted;
    logic            pc_wrap;

    modport master (
        input  run, ex_busy, rom_data,
        output rom_addr, ir, alu_en, reg_we, out_en, halted, pc_wrap
    );

    modport slave (
        output run, ex_busy, rom_data,
        input  rom_addr, ir, alu_en, reg_we, out_en, halted, pc_wrap
    );
endinterface

// File: rtl/proc_decode.sv
// Combinational opcode -> instruction class decode; unknown opcodes behave as NOP.
module proc_decode
    import proc_pkg::*;
(
    input  logic [3:0] i_opcode,
    output iclass_t    o_class
);

    always_comb begin
        o_class = CL_NOP;
        case (i_opcode)
            OP_ADDI, OP_ADD: o_class = CL_ALU;
            OP_OUT:          o_class = CL_OUT;
            OP_JMP:          o_class = CL_JMP;
            OP_HALT:         o_class = CL_HALT;
            default:         o_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/proc_sequencer.sv
// Fetch/decode/execute/writeback controller: owns the PC, latches ir, issues datapath strobes.
// Optional PROC_SEQ_SINGLE_STEP_EN adds a step input: one instruction per step rising edge.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IW   = IW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PROC_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    proc_sequencer_if.master  bus,
    output state_t            o_dbg_state
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [IW-1:0]   r_ir;
    iclass_t         r_class;
    logic            r_alu_en;
    logic            r_reg_we;
    logic            r_out_arm;
    logic            r_halted;
    logic            r_pc_wrap;

    iclass_t         w_class;
    logic            w_go_fetch;
    logic            w_continue;

    proc_decode u_decode (
        .i_opcode (get_opcode(r_ir)),
        .o_class  (w_class)
    );

`ifdef PROC_SEQ_SINGLE_STEP_EN
    logic r_step_d;
    logic r_step_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_d    <= 1'b0;
            r_step_rise <= 1'b0;
        end else begin
            r_step_d    <= step;
            r_step_rise <= step & ~r_step_d;
        end
    end

    // Every instruction ends in IDLE; only a fresh step edge starts the next one.
    assign w_go_fetch = bus.run & r_step_rise;
    assign w_continue = 1'b0;
`else
    assign w_go_fetch = bus.run;
    assign w_continue = bus.run;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_class   <= CL_NOP;
            r_alu_en  <= 1'b0;
            r_reg_we  <= 1'b0;
            r_out_arm <= 1'b0;
            r_halted  <= 1'b0;
            r_pc_wrap <= 1'b0;
        end else begin
            r_reg_we  <= 1'b0;
            r_pc_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_fetch) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_ir    <= bus.rom_data;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_class   <= w_class;
                    r_alu_en  <= (w_class == CL_ALU);
                    r_out_arm <= (w_class == CL_OUT);
                    r_state   <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (!bus.ex_busy) begin
                        r_alu_en  <= 1'b0;
                        r_out_arm <= 1'b0;
                        case (r_class)
                            CL_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= ST_HALT;
                            end
                            CL_JMP: begin
                                r_pc    <= r_ir[PC_W-1:0];
                                r_state <= w_continue ? ST_FETCH : ST_IDLE;
                            end
                            default: begin
                                r_reg_we  <= (r_class == CL_ALU);
                                r_pc_wrap <= (r_pc == '1);
                                r_state   <= ST_WRITEBACK;
                            end
                        endcase
                    end
                end
                ST_WRITEBACK: begin
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= w_continue ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // out_en fires on the EXECUTE exit cycle, so it alone sees ex_busy combinationally.
    assign bus.out_en   = r_out_arm & ~bus.ex_busy;
    assign bus.rom_addr = r_pc;
    assign bus.ir       = r_ir;
    assign bus.alu_en   = r_alu_en;
    assign bus.reg_we   = r_reg_we;
    assign bus.halted   = r_halted;
    assign bus.pc_wrap  = r_pc_wrap;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: an instruction-level model builds a per-cycle script of
// inputs and expected outputs, which the driver replays against the DUT.
module tb_proc_sequencer;
  import proc_pkg::*;

  localparam int EXP_W = 25;

  logic clk;
  logic rst_n;
  state_t dbg_state;
  logic [15:0] rom [16];

  proc_sequencer_if bus ();

`ifdef PROC_SEQ_SINGLE_STEP_EN
  logic step;
`endif

  proc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef PROC_SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard queues: stimulus {run, ex_busy} and expected {addr, ir, alu, we, oe, wrap, halt}
  logic [1:0]       stim_q[$];
  logic [EXP_W-1:0] exp_q[$];

  logic [3:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_halted;
  bit          g_rand_run;

  task automatic push(input bit run, input bit busy, input logic [3:0] addr, input logic [15:0] ir,
                      input bit alu, input bit we, input bit oe, input bit wrap, input bit halt);
    stim_q.push_back({run, busy});
    exp_q.push_back({addr, ir, alu, we, oe, wrap, halt});
  endtask

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic bit pick_run();
    return g_rand_run ? ($urandom_range(0, 2) != 0) : 1'b1;
  endfunction

  task automatic idle_phase();
    int n;
    bit r;
    n = 0;
    do begin
      r = pick_run();
      if (n >= 3) r = 1'b1;
      push(r, rnd_bit(), m_pc, m_ir, 0, 0, 0, 0, 0);
      n++;
    end while (!r);
  endtask

  // Instruction-level model: FETCH, DECODE, EXECUTE (+stalls), WRITEBACK unless JMP/HALT.
  task automatic gen_script(input int n_instr, input int max_stall, input int halt_cycles, input bit tail);
    logic [15:0] w;
    logic [3:0]  op;
    bit is_alu, is_out, is_jmp, is_halt, last_run;
    int s, done;
    m_pc = 4'd0;
    m_ir = 16'd0;
    m_halted = 1'b0;
    done = 0;
    idle_phase();
    while (done < n_instr) begin
      w = rom[m_pc];
      op = w[15:12];
      is_alu  = (op == 4'h1) || (op == 4'h2);
      is_out  = (op == 4'hF);
      is_jmp  = (op == 4'hE);
      is_halt = (op == 4'hD);
      push(rnd_bit(), rnd_bit(), m_pc, m_ir, 0, 0, 0, 0, 0);
      m_ir = w;
      push(rnd_bit(), rnd_bit(), m_pc, m_ir, 0, 0, 0, 0, 0);
      s = $urandom_range(0, max_stall);
      done++;
      last_run = (done >= n_instr) ? 1'b1 : pick_run();
      for (int k = 0; k <= s; k++)
        push((k == s && is_jmp) ? last_run : rnd_bit(), k < s, m_pc, m_ir,
             is_alu, 0, is_out && (k == s), 0, 0);
      if (is_halt) begin
        m_halted = 1'b1;
        for (int h = 0; h < halt_cycles; h++)
          push(rnd_bit(), rnd_bit(), m_pc, m_ir, 0, 0, 0, 0, 1);
        return;
      end
      if (is_jmp) begin
        m_pc = w[3:0];
      end else begin
        push(last_run, rnd_bit(), m_pc, m_ir, 0, is_alu, 0, m_pc == 4'hF, 0);
        m_pc = m_pc + 4'd1;
      end
      if (!last_run) idle_phase();
    end
    if (tail) begin
      w = rom[m_pc];
      op = w[15:12];
      push(1, rnd_bit(), m_pc, m_ir, 0, 0, 0, 0, 0);
      m_ir = w;
      push(1, rnd_bit(), m_pc, m_ir, 0, 0, 0, 0, 0);
      push(1, 1, m_pc, m_ir, (op == 4'h1) || (op == 4'h2), 0, 0, 0, 0);
    end
  endtask

  task automatic run_script();
    logic [1:0]       s;
    logic [EXP_W-1:0] e;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      bus.run = s[1];
      bus.ex_busy = s[0];
      #1;
      check_eq("rom_addr", 32'(bus.rom_addr), 32'(e[24:21]));
      check_eq("ir", 32'(bus.ir), 32'(e[20:5]));
      check_eq("alu_en", 32'(bus.alu_en), 32'(e[4]));
      check_eq("reg_we", 32'(bus.reg_we), 32'(e[3]));
      check_eq("out_en", 32'(bus.out_en), 32'(e[2]));
      check_eq("pc_wrap", 32'(bus.pc_wrap), 32'(e[1]));
      check_eq("halted", 32'(bus.halted), 32'(e[0]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_addr"}, 32'(bus.rom_addr), 32'd0);
    check_eq({tag, "_ir"}, 32'(bus.ir), 32'd0);
    check_eq({tag, "_strobes"}, 32'({bus.alu_en, bus.reg_we, bus.out_en, bus.halted, bus.pc_wrap}), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.ex_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  // Called one cycle into a stalled EXECUTE (or in HALT): reset must clear outputs at once.
  task automatic async_reset();
    check_eq("pre_rst_state", 32'(dbg_state), m_halted ? 32'(ST_HALT) : 32'(ST_EXECUTE));
    bus.run = 1'b1;
    bus.ex_busy = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    check_reset_vals("held_rst");
    rst_n = 1'b1;
  endtask

  task automatic load_rom_random();
    logic [3:0] op;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hD && $urandom_range(0, 3) != 0) op = 4'h0;
      rom[i] = {op, 12'($urandom_range(0, 4095))};
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.ex_busy = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
`ifdef PROC_SEQ_SINGLE_STEP_EN
    begin
      int n_we;
      step = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 16'h1001;
      do_reset();
      bus.run = 1'b1;
      n_we = 0;
      repeat (3) begin
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (10) begin
          if (bus.reg_we) n_we++;
          @(posedge clk);
          #1;
        end
      end
      check_eq("step_instr_count", 32'(n_we), 32'd3);
      check_eq("step_pc", 32'(bus.rom_addr), 32'd3);
      check_eq("step_state", 32'(dbg_state), 32'(ST_IDLE));
    end
`else
    do_reset();

    // ADDI, OUT, ADD, NOP, unknown-as-NOP, JMP 2
    rom[0] = 16'h1203; rom[1] = 16'hF200; rom[2] = 16'h2240;
    rom[3] = 16'h0000; rom[4] = 16'h7123; rom[5] = 16'hE002;
    g_rand_run = 1'b0;
    gen_script(8, 0, 0, 1'b1);
    run_script();
    async_reset();

    g_rand_run = 1'b1;
    gen_script(10, 3, 0, 1'b1);
    run_script();
    async_reset();

    // JMP to 14, PC wraps 15 -> 0, loops
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'hE00E; rom[14] = 16'h1005; rom[15] = 16'hF000;
    gen_script(12, 2, 0, 1'b1);
    run_script();
    async_reset();

    // HALT at 3 with run toggling afterwards
    rom[0] = 16'h1203; rom[1] = 16'hF200; rom[2] = 16'h0000; rom[3] = 16'hD000;
    gen_script(10, 1, 12, 1'b1);
    run_script();
    async_reset();

    repeat (6) begin
      load_rom_random();
      gen_script(20, 3, 10, 1'b1);
      run_script();
      async_reset();
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Multi-cycle fetch/decode/execute controller for the 4-bit-address processor. Owns the program counter, drives the program ROM address, latches the instruction word, and issues one-cycle control strobes (ALU enable, register write, output enable) to the datapath. Sits between the combinational program ROM and the register file/ALU/output port; one instruction is in flight at a time.

## Interface
Parameters:
- PC_W, 4, program counter / ROM address width (16-entry ROM)
- IW, 16, instruction width

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; high = execute instructions, low = finish current instruction then idle
- ex_busy  in  1  datapath stall; holds EXECUTE while high
- rom_addr  out  PC_W  program ROM address (= PC)
- rom_data  in  IW  ROM instruction, combinational from rom_addr
- ir  out  IW  latched instruction register
- alu_en  out  1  datapath computes this cycle
- reg_we  out  1  register file write strobe, rd = ir[11:9]
- out_en  out  1  output-port load strobe, source = ir[11:9]
- halted  out  1  high in HALT state
- pc_wrap  out  1  one-cycle pulse when PC advances 15 -> 0

## Operation
- Instruction: opcode ir[15:12], rd ir[11:9], rs ir[8:6], imm/target ir[3:0].
- Opcodes: 0000 NOP, 0001 ADDI, 0010 ADD, 1110 JMP, 1101 HALT, 1111 OUT; all others decode as NOP.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: ir <= rom_data at rom_addr=PC -> DECODE.
- DECODE: opcode registered into class (ALU/OUT/JMP/HALT/NOP) -> EXECUTE.
- EXECUTE: alu_en=1 every cycle for ADDI/ADD; ex_busy=1 holds state. On the exit cycle (ex_busy=0): out_en=1 for OUT; HALT -> HALT; JMP -> PC <= ir[3:0]; all others -> WRITEBACK.
- JMP exits EXECUTE to FETCH (if run) or IDLE, skipping WRITEBACK.
- WRITEBACK: reg_we=1 for ADDI/ADD; PC <= PC+1 mod 16; -> FETCH if run else IDLE.
- HALT: terminal; only rst_n exits. All strobes low, halted=1.
- PC arithmetic: unsigned PC_W-bit, wraps 15 -> 0; pc_wrap=1 in that WRITEBACK cycle only. JMP never asserts pc_wrap.
- run sampled only in IDLE and at instruction end; deassertion mid-instruction completes the instruction.
- ex_busy ignored outside EXECUTE.

## Timing
- Reset (async assert, sync release): PC=0, ir=0, state IDLE; rom_addr=0, alu_en=reg_we=out_en=halted=pc_wrap=0.
- Strobes decoded from registered state/ir: no combinational path from ex_busy or run to any output except out_en (gated by ex_busy).
- Unstalled latency: 4 cycles per ALU/OUT/NOP instruction (FETCH, DECODE, EXECUTE, WRITEBACK); JMP 3 cycles; each ex_busy cycle adds 1.
- rom_addr stable through FETCH; ROM must settle within one cycle.
- reg_we and out_en each assert exactly once per qualifying instruction.

## Configuration
- PROC_SEQ_SINGLE_STEP_EN defined: adds input step (1 bit). At each instruction end the sequencer enters IDLE regardless of run; IDLE -> FETCH only on a step rising edge (registered edge detect) while run=1. Exactly one instruction per step pulse.
- Undefined: no step port; behaviour as above (free-running while run=1).

## Structure
- Shared package proc_pkg: opcode localparams, state encoding, instruction field bit positions, PC_W/IW defaults; also used by datapath and ROM.
- One sub-module: proc_decode (combinational opcode -> class/strobe-enable decode), instantiated once inside proc_sequencer.

## Test plan
- Reset mid-EXECUTE (rst_n low 1 cycle) -> all outputs at reset values same cycle; PC=0, state IDLE after release.
- ROM[0]=0x1203 (ADDI r1,3), run=1 -> FETCH at cycle 1, alu_en cycle 3, reg_we cycle 4, rom_addr=1 cycle 5.
- ROM[1]=0xF200 (OUT r1), ex_busy high 3 cycles in EXECUTE -> alu_en low, out_en single pulse on 4th EXECUTE cycle, instruction takes 7 cycles.
- ROM[5]=0xE002 (JMP 2) -> rom_addr=2 next FETCH, no reg_we, no pc_wrap; ROM[15]=NOP -> pc_wrap pulse, rom_addr=0.
- ROM[3]=0xD000 (HALT) -> halted=1 permanently, run toggling has no effect until rst_n.
- With PROC_SEQ_SINGLE_STEP_EN, run=1, three step pulses -> exactly three instructions executed, PC=3, state IDLE.
